// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM core arbiter.
package sdram_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int MAX_PORTS = 8;

    // First set bit of req at or after ptr, searching cyclically over n ports; 0 if none.
    function automatic logic [2:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                           input logic [2:0]           ptr,
                                           input int                   n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (i < n && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sdram_core_arb_if.sv
// Downstream SDRAM core request/completion bus.
interface sdram_core_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH/8
);
    logic [BE_WIDTH-1:0]   m_wr;
    logic                  m_rd;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [DATA_WIDTH-1:0] m_write_data;
    logic                  m_accept;
    logic                  m_ack;
    logic                  m_error;
    logic [DATA_WIDTH-1:0] m_read_data;

    modport master (
        output m_wr, m_rd, m_addr, m_write_data,
        input  m_accept, m_ack, m_error, m_read_data
    );

    modport slave (
        input  m_wr, m_rd, m_addr, m_write_data,
        output m_accept, m_ack, m_error, m_read_data
    );
endinterface

// File: rtl/sdram_tag_fifo.sv
// In-order port-ID tag FIFO; DEPTH must be a power of two so pointers wrap naturally.
module sdram_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/sdram_core_arb.sv
// N-port round-robin arbiter onto one SDRAM core port, with in-order ack routing.
// Optional SDRAM_CORE_ARB_PRIO0_EN: port 0 gets fixed top priority, others round-robin.
module sdram_core_arb
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = DATA_WIDTH/8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PORT_W          = $clog2(NUM_PORTS)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0][BE_WIDTH-1:0]    p_wr,
    input  logic [NUM_PORTS-1:0]                  p_rd,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  p_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  p_write_data,
    output logic [NUM_PORTS-1:0]                  p_accept,
    output logic [NUM_PORTS-1:0]                  p_ack,
    output logic [NUM_PORTS-1:0]                  p_error,
    output logic [DATA_WIDTH-1:0]                 p_read_data,
    sdram_core_arb_if.master                      m,
    output logic                                  spurious_ack
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_t           state_q, state_d;
    logic [PORT_W-1:0]    g_q, g_d, rr_ptr_q, rr_d, pick, g_nxt;
    logic [NUM_PORTS-1:0] req;
    logic [MAX_PORTS-1:0] req_ext;
    logic                 push, pop, tag_full, tag_empty;
    logic [PORT_W-1:0]    head;
    logic [CNT_W-1:0]     tag_cnt;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) req[i] = (|p_wr[i]) | p_rd[i];
    end

    always_comb begin
        req_ext = '0;
        req_ext[NUM_PORTS-1:0] = req;
`ifdef SDRAM_CORE_ARB_PRIO0_EN
        if (req[0]) pick = '0;
        else        pick = PORT_W'(rr_pick(req_ext & ~8'h01, 3'(rr_ptr_q), NUM_PORTS));
`else
        pick = PORT_W'(rr_pick(req_ext, 3'(rr_ptr_q), NUM_PORTS));
`endif
    end

    assign g_nxt = (g_q == PORT_W'(NUM_PORTS-1)) ? '0 : g_q + PORT_W'(1);

    always_comb begin
        state_d        = state_q;
        g_d            = g_q;
        rr_d           = rr_ptr_q;
        push           = 1'b0;
        p_accept       = '0;
        m.m_wr         = '0;
        m.m_rd         = 1'b0;
        m.m_addr       = '0;
        m.m_write_data = '0;
        unique case (state_q)
            IDLE: begin
                // Full is judged on the registered count; a same-cycle pop does not open a slot.
                if (|req && tag_cnt < CNT_W'(MAX_OUTSTANDING)) begin
                    state_d = GRANT;
                    g_d     = pick;
                end
            end
            GRANT: begin
                m.m_wr         = p_wr[g_q];
                m.m_rd         = p_rd[g_q] & ~(|p_wr[g_q]);
                m.m_addr       = p_addr[g_q];
                m.m_write_data = p_write_data[g_q];
                if (!req[g_q]) begin
                    state_d = IDLE;
                end else if (m.m_accept) begin
                    p_accept[g_q] = 1'b1;
                    push          = 1'b1;
                    state_d       = IDLE;
`ifdef SDRAM_CORE_ARB_PRIO0_EN
                    if (g_q != '0) rr_d = g_nxt;
`else
                    rr_d = g_nxt;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            g_q          <= '0;
            rr_ptr_q     <= '0;
            spurious_ack <= 1'b0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            rr_ptr_q <= rr_d;
            if (m.m_ack && tag_empty) spurious_ack <= 1'b1;
        end
    end

    assign pop = m.m_ack & ~tag_empty;

    sdram_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (PORT_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push & ~tag_full),
        .din   (g_q),
        .pop   (pop),
        .dout  (head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_cnt)
    );

    always_comb begin
        p_ack   = '0;
        p_error = '0;
        if (pop) begin
            p_ack[head]   = 1'b1;
            p_error[head] = m.m_error;
        end
    end

    assign p_read_data = m.m_read_data;
endmodule

// File: tb/tb_sdram_core_arb.sv
// Bench for sdram_core_arb: queue-based arbitration model checked every cycle plus directed literal checks.
module tb_sdram_core_arb;
    localparam int NP = 4, AW = 32, DW = 32, BE = 4, MO = 4;
`ifdef SDRAM_CORE_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NP-1:0][BE-1:0] p_wr;
    logic [NP-1:0]         p_rd;
    logic [NP-1:0][AW-1:0] p_addr;
    logic [NP-1:0][DW-1:0] p_write_data;
    logic [NP-1:0]         p_accept, p_ack, p_error;
    logic [DW-1:0]         p_read_data;
    logic                  spurious_ack;

    logic          auto_ack = 1'b1, man_ack = 1'b0, man_err = 1'b0, m_acc = 1'b0;
    logic [DW-1:0] man_data = '0;
    logic          resp_ack = 1'b0, pend = 1'b0;
    logic [DW-1:0] resp_data = '0, pend_data = '0;

    int n_cmp = 0, n_bad = 0;
    int acc_log[$];

    sdram_core_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BE)) bus ();
    assign bus.m_accept    = m_acc;
    assign bus.m_ack       = auto_ack ? resp_ack : man_ack;
    assign bus.m_error     = auto_ack ? 1'b0 : man_err;
    assign bus.m_read_data = auto_ack ? resp_data : man_data;

    sdram_core_arb #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BE), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .p_wr(p_wr), .p_rd(p_rd), .p_addr(p_addr),
        .p_write_data(p_write_data), .p_accept(p_accept), .p_ack(p_ack), .p_error(p_error),
        .p_read_data(p_read_data), .m(bus), .spurious_ack(spurious_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Downstream responder: acks each accepted request one cycle later with 0xA0+port.
    always @(negedge clk) begin
        pend      = 1'b0;
        pend_data = '0;
        for (int i = 0; i < NP; i++)
            if (p_accept[i]) begin
                pend      = 1'b1;
                pend_data = 32'hA0 + 32'(i);
            end
    end
    always @(posedge clk) begin
        resp_ack  <= pend;
        resp_data <= pend_data;
    end

    // Grant log and read-data routing check for responder-generated acks.
    always @(negedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (p_accept[i]) acc_log.push_back(i);
            if (p_ack[i] && auto_ack) check("ack_rdata", p_read_data, 32'hA0 + 32'(i));
        end
    end

    function automatic int model_pick(input logic [NP-1:0] r, input int ptr);
        int idx;
        if (PRIO && r[0]) return 0;
        for (int k = 0; k < NP; k++) begin
            idx = (ptr + k) % NP;
            if (!(PRIO && idx == 0) && r[idx]) return idx;
        end
        return 0;
    endfunction

    // Behavioural model: at most one granted owner, FIFO of owner tags, round-robin pointer.
    int  tags[$];
    bit  busy = 0, spur = 0, chk_en = 0;
    int  owner = 0, rr = 0;
    always @(negedge clk) begin
        logic [NP-1:0] req, e_acc, e_ack, e_err;
        logic [BE-1:0] e_wr;
        logic          e_rd;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        int            cnt0;
        for (int i = 0; i < NP; i++) req[i] = (p_wr[i] != '0) || p_rd[i];
        e_acc = '0; e_ack = '0; e_err = '0; e_wr = '0; e_rd = 1'b0; e_addr = '0; e_wd = '0;
        if (busy) begin
            e_wr   = p_wr[owner];
            e_rd   = p_rd[owner] && (p_wr[owner] == '0);
            e_addr = p_addr[owner];
            e_wd   = p_write_data[owner];
            if (req[owner] && bus.m_accept) e_acc[owner] = 1'b1;
        end
        if (bus.m_ack && tags.size() > 0) begin
            e_ack[tags[0]] = 1'b1;
            e_err[tags[0]] = bus.m_error;
        end
        if (chk_en) begin
            check("m_wr", bus.m_wr, e_wr);
            check("m_rd", bus.m_rd, e_rd);
            check("m_addr", bus.m_addr, e_addr);
            check("m_write_data", bus.m_write_data, e_wd);
            check("p_accept", p_accept, e_acc);
            check("p_ack", p_ack, e_ack);
            check("p_error", p_error, e_err);
            check("p_read_data", p_read_data, bus.m_read_data);
            check("spurious_ack", spurious_ack, spur);
        end
        if (!rst_n) begin
            busy = 0; owner = 0; rr = 0; spur = 0; chk_en = 1;
            tags.delete();
        end else begin
            cnt0 = tags.size();
            if (bus.m_ack) begin
                if (tags.size() > 0) void'(tags.pop_front());
                else spur = 1;
            end
            if (busy) begin
                if (!req[owner]) busy = 0;
                else if (bus.m_accept) begin
                    tags.push_back(owner);
                    busy = 0;
                    if (!PRIO || owner != 0) rr = (owner + 1) % NP;
                end
            end else if (req != '0 && cnt0 < MO) begin
                owner = model_pick(req, rr);
                busy  = 1;
            end
        end
    end

    task automatic wait_acc(input int port, input int lim);
        bit seen = 0;
        for (int c = 0; c < lim && !seen; c++) begin
            @(negedge clk);
            if (p_accept[port]) seen = 1;
        end
        check($sformatf("acc_wait_p%0d", port), 64'(seen), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int exp_rr[5];
        exp_rr = '{0, 1, 2, 3, 0};
        p_wr = '0; p_rd = '0;
        for (int i = 0; i < NP; i++) begin
            p_addr[i]       = 32'h1000 * 32'(i + 1);
            p_write_data[i] = 32'h5A00_0000 + 32'(i);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state, idle
        repeat (2) @(negedge clk);
        check("rst_accept", p_accept, 0);
        check("rst_ack", p_ack, 0);
        check("rst_m_rd", bus.m_rd, 0);
        check("rst_m_wr", bus.m_wr, 0);
        check("rst_spur", spurious_ack, 0);

        // All ports read continuously: grants 0,1,2,3,0
        @(posedge clk); #1;
        base = acc_log.size();
        m_acc = 1'b1; p_rd = '1;
        repeat (11) @(posedge clk);
        #1 p_rd = '0;
        repeat (4) @(posedge clk);
        check("rr_count", 64'(acc_log.size() - base), 64'd5);
        for (int k = 0; k < 5; k++)
            if (base + k < acc_log.size()) check("rr_order", 64'(acc_log[base + k]), 64'(exp_rr[k]));

        // Error completion routed to port 1
        #1 auto_ack = 1'b0; p_rd[1] = 1'b1;
        wait_acc(1, 10);
        @(posedge clk); #1;
        p_rd[1] = 1'b0; man_ack = 1'b1; man_err = 1'b1; man_data = 32'hDEAD_BEEF;
        @(negedge clk);
        check("err_ack", p_ack, 4'b0010);
        check("err_err", p_error, 4'b0010);
        check("err_rdata", p_read_data, 32'hDEAD_BEEF);
        @(posedge clk); #1 man_ack = 1'b0; man_err = 1'b0;

        // Port 2 writes with acks withheld: 4 accepted, then held at full
        base = acc_log.size();
        p_wr[2] = 4'hF;
        repeat (14) @(negedge clk);
        check("bp_held", 64'(acc_log.size() - base), 64'd4);
        check("bp_idle_wr", bus.m_wr, 0);
        @(posedge clk); #1 man_ack = 1'b1;
        @(negedge clk);
        check("bp_pop_ack", p_ack, 4'b0100);
        check("bp_full_idle", bus.m_wr, 0);
        @(posedge clk); #1 man_ack = 1'b0;
        @(negedge clk);
        check("bp_grant_pending", bus.m_wr, 0);
        @(negedge clk);
        check("bp_regrant_wr", bus.m_wr, 4'hF);
        check("bp_regrant_acc", p_accept, 4'b0100);
        @(posedge clk); #1 p_wr[2] = 4'h0;
        check("bp_total", 64'(acc_log.size() - base), 64'd5);
        man_ack = 1'b1;
        repeat (4) @(posedge clk);
        #1 man_ack = 1'b0;

        // Spurious ack with empty FIFO is sticky until reset
        @(negedge clk);
        check("spur_pre", spurious_ack, 0);
        @(posedge clk); #1 man_ack = 1'b1;
        @(negedge clk);
        check("spur_no_ack", p_ack, 0);
        @(posedge clk); #1 man_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("spur_sticky", spurious_ack, 1);

        // Reset with a tag outstanding: tag discarded, later ack is spurious
        @(posedge clk); #1 p_rd[3] = 1'b1;
        wait_acc(3, 10);
        @(posedge clk); #1 p_rd[3] = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_spur", spurious_ack, 0);
        @(posedge clk); #1 man_ack = 1'b1;
        @(negedge clk);
        check("rst_mid_no_ack", p_ack, 0);
        @(posedge clk); #1 man_ack = 1'b0;
        @(negedge clk);
        check("rst_mid_spur_set", spurious_ack, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("spur_cleared", spurious_ack, 0);

`ifdef SDRAM_CORE_ARB_PRIO0_EN
        // Port 0 dominates; without it ports 1 and 3 alternate
        auto_ack = 1'b1;
        @(posedge clk); #1;
        base = acc_log.size();
        p_rd = 4'b1011;
        repeat (8) @(negedge clk);
        @(posedge clk); #1 p_rd = 4'b1010;
        repeat (8) @(negedge clk);
        @(posedge clk); #1 p_rd = '0;
        repeat (3) @(posedge clk);
        check("prio_count", 64'(acc_log.size() - base), 64'd8);
        for (int k = 0; k < 8; k++)
            if (base + k < acc_log.size())
                check("prio_order", 64'(acc_log[base + k]), (k < 4) ? 64'd0 : ((k % 2 == 0) ? 64'd1 : 64'd3));
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_core_arb.md
Name: sdram_core_arb

Overview:
- N-port arbiter that merges NUM_PORTS core-side managers onto one SDRAM core subordinate port. This is the multi-channel successor of the single-manager core interface.
- Round-robin grant, with the grant locked until the downstream accepts.
- Every accepted request records its port ID in an in-order tag FIFO, so returning ack/error is routed to the correct port.
- Sits between CPU/DMA/video masters and the SDRAM controller.

Parameters:
- NUM_PORTS, 4, number of upstream managers (2..8)
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; multiple of 8
- BE_WIDTH, DATA_WIDTH/8, write byte-enable width
- MAX_OUTSTANDING, 4, tag FIFO depth (power of 2)
- PORT_W, $clog2(NUM_PORTS), port ID width

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- p_wr  in  NUM_PORTS*BE_WIDTH  per-port write byte enables; nonzero = write request
- p_rd  in  NUM_PORTS  per-port read request
- p_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address
- p_write_data  in  NUM_PORTS*DATA_WIDTH  per-port write data
- p_accept  out  NUM_PORTS  request taken this cycle
- p_ack  out  NUM_PORTS  completion for the oldest outstanding request of that port
- p_error  out  NUM_PORTS  error qualifier, valid with p_ack
- p_read_data  out  DATA_WIDTH  broadcast read data, valid with p_ack
- m_wr  out  BE_WIDTH  downstream write enables
- m_rd  out  1  downstream read
- m_addr  out  ADDR_WIDTH  downstream address
- m_write_data  out  DATA_WIDTH  downstream write data
- m_accept  in  1  downstream accepted request
- m_ack  in  1  downstream completion, in issue order
- m_error  in  1  downstream error, with m_ack
- m_read_data  in  DATA_WIDTH  downstream read data
- spurious_ack  out  1  sticky: m_ack received with tag FIFO empty

Behaviour:
- Port request req[i] = |p_wr[i] | p_rd[i]. A port asserting both is a write; the read bit is ignored.
- FSM states:
  - IDLE: no grant.
  - GRANT: grant register g holds the owning port.
- IDLE -> GRANT:
  - Taken when any req is set and tag count < MAX_OUTSTANDING.
  - g = first requester at or after rr_ptr, searching cyclically.
  - The transition is registered, so the downstream request appears one cycle after the upstream request is first seen.
- In GRANT:
  - m_* is a combinational mux of port g's signals.
  - p_accept[g] = m_accept; all other p_accept are 0.
- GRANT -> IDLE:
  - On m_accept: push g into the tag FIFO and set rr_ptr = g+1 mod NUM_PORTS.
  - If req[g] drops before accept (protocol violation): return to IDLE with no push; rr_ptr unchanged.
- While in IDLE, m_wr = 0 and m_rd = 0. m_addr and m_write_data are driven 0.
- Completion path:
  - On m_ack with FIFO non-empty: pop the head tag h.
  - p_ack[h] = 1 and p_error[h] = m_error, combinationally in the same cycle.
  - p_read_data = m_read_data always.
- Completion with FIFO empty: ack is dropped, no p_ack asserts, and spurious_ack sets. Only reset clears it.
- Simultaneous push and pop: allowed; count is unchanged and the popped tag is the old head.
- Full condition:
  - At count == MAX_OUTSTANDING, the FSM does not leave IDLE, even if a pop occurs that cycle.
  - A GRANT already in progress completes normally; the grant is only entered when not full, so the push has room.
- Count arithmetic:
  - Read/write pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally.
  - Count is one bit wider.
- Reset values:
  - State IDLE, g = 0, rr_ptr = 0, FIFO empty, spurious_ack = 0.
  - All p_accept, p_ack, p_error = 0; m_wr = 0, m_rd = 0.
- Reset mid-operation: the in-flight grant is abandoned and tags are discarded. Acks arriving after reset flag spurious_ack.

Optional Feature:
- Macro SDRAM_CORE_ARB_PRIO0_EN.
- Defined:
  - Port 0 has fixed highest priority: in IDLE, req[0] wins regardless of rr_ptr.
  - Remaining ports round-robin among themselves.
  - rr_ptr is not updated on a port-0 grant.
- Undefined: pure round-robin across all ports.

Decomposition:
- Package sdram_arb_pkg:
  - arb_state_t enum (IDLE, GRANT)
  - round-robin pick function (req vector, pointer) -> index
- Sub-module sdram_tag_fifo:
  - Parametrised depth/width synchronous FIFO
  - push/pop/full/empty/count ports
  - Same reset style

Test Plan:
- Reset release, no requests -> all outputs 0, m_rd = m_wr = 0, spurious_ack = 0.
- Ports 0..3 all request reads every cycle, m_accept = 1, m_ack one cycle later -> grants in order 0,1,2,3,0. Each ack lands on the matching p_ack, with read_data 0xA0+port.
- 5 writes from port 2 with m_ack withheld -> 4 accepted, 5th held in IDLE. One m_ack frees a slot and the 5th is granted on the next cycle.
- m_ack with m_error = 1 for the tag of port 1 -> p_ack[1] = p_error[1] = 1; all other ports 0.
- m_ack pulse with FIFO empty -> no p_ack; spurious_ack = 1 and stays set until rst_n = 0.
- With SDRAM_CORE_ARB_PRIO0_EN: port 0 requests continuously while ports 1 and 3 request -> port 0 granted each free slot; with port 0 idle, ports 1 and 3 alternate.
